// File: rtl/round_rr_arbiter.sv
// Two-requester round-robin front end for a shared round-half-up stage.
// Results are registered once and tagged with the index of the requester that produced them.
module round_rr_arbiter #(
  parameter int DIN   = 16,
  parameter int NBITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  output logic           din0_ready,
  input  logic           din0_valid,
  input  logic [DIN-1:0] din0_data,
  output logic           din1_ready,
  input  logic           din1_valid,
  input  logic [DIN-1:0] din1_data,
  input  logic           dout_ready,
  output logic           dout_valid,
  output logic [DIN-1:0] dout_data,
  output logic           dout_src
);

  localparam logic [DIN-1:0] HALF      = DIN'(1) << (NBITS - 1);
  localparam logic [DIN-1:0] KEEP_MASK = {DIN{1'b1}} << NBITS;

  logic           prio;
  logic           load_en;
  logic           grant;
  logic           xfer;
  logic [DIN-1:0] sel_data;
  logic [DIN-1:0] rounded;

  // A contended cycle goes to prio; a lone requester always wins.
  always_comb begin
    load_en    = ~dout_valid | dout_ready;
    grant      = (din0_valid & din1_valid) ? prio : din1_valid;
    din0_ready = load_en & din0_valid & ~grant & ~rst;
    din1_ready = load_en & din1_valid & grant & ~rst;
    xfer       = din0_ready | din1_ready;
    sel_data   = grant ? din1_data : din0_data;
    rounded    = (sel_data + HALF) & KEEP_MASK;
  end

  // Draining without a new transfer keeps the old data and source visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_src   <= 1'b0;
      prio       <= 1'b0;
    end else if (xfer) begin
      dout_valid <= 1'b1;
      dout_data  <= rounded;
      dout_src   <= grant;
      prio       <= ~grant;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_round_rr_arbiter.sv
// Bench for round_rr_arbiter: a cycle table with hand-derived ready expectations and
// a scoreboard of rounded results that is filled on each transfer and emptied as the output drains.
module tb_round_rr_arbiter;

  localparam int DIN   = 16;
  localparam int NBITS = 4;

  logic           clk;
  logic           rst;
  logic           din0_ready;
  logic           din0_valid;
  logic [DIN-1:0] din0_data;
  logic           din1_ready;
  logic           din1_valid;
  logic [DIN-1:0] din1_data;
  logic           dout_ready;
  logic           dout_valid;
  logic [DIN-1:0] dout_data;
  logic           dout_src;

  round_rr_arbiter #(.DIN(DIN), .NBITS(NBITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .din0_ready (din0_ready),
    .din0_valid (din0_valid),
    .din0_data  (din0_data),
    .din1_ready (din1_ready),
    .din1_valid (din1_valid),
    .din1_data  (din1_data),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_src   (dout_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit             rst;
    bit             v0;
    logic [DIN-1:0] d0;
    bit             v1;
    logic [DIN-1:0] d1;
    bit             dr;
    bit             er0;
    bit             er1;
  } vec_t;

  typedef struct {
    logic [DIN-1:0] data;
    bit             src;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   model_valid;

  function automatic logic [DIN-1:0] round_ref(input logic [DIN-1:0] d);
    int unsigned t;
    t = ((int'(d) >> (NBITS - 1)) + 1) >> 1;
    return DIN'((t << NBITS) & ((1 << DIN) - 1));
  endfunction

  function automatic void add(input bit r, input bit v0, input logic [DIN-1:0] d0,
                              input bit v1, input logic [DIN-1:0] d1, input bit dr,
                              input bit er0, input bit er1);
    vec_t v;
    v.rst = r; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.dr = dr; v.er0 = er0; v.er1 = er1;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    din0_valid = v.v0;
    din0_data  = v.d0;
    din1_valid = v.v1;
    din1_data  = v.d1;
    dout_ready = v.dr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    rst = 1'b1; din0_valid = 1'b0; din0_data = '0;
    din1_valid = 1'b0; din1_data = '0; dout_ready = 1'b0;

    // rst=1 for two cycles; a valid requester must still see ready low.
    @(posedge clk); #1;
    din0_valid = 1'b1; din0_data = 16'h0017; dout_ready = 1'b1; #1;
    checkOutput("rst din0_ready", din0_ready, 0);
    checkOutput("rst din1_ready", din1_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; din0_valid = 1'b0; #1;
    checkOutput("reset dout_valid", dout_valid, 0);
    checkOutput("reset dout_data", dout_data, 0);
    checkOutput("reset dout_src", dout_src, 0);
    checkOutput("idle din0_ready", din0_ready, 0);
    checkOutput("idle din1_ready", din1_ready, 0);
    model_valid = 1'b0;

    //   rst  v0  d0        v1  d1        dr  er0 er1
    add(0, 1, 16'h0017, 0, 16'h0000, 1, 1, 0);
    add(0, 1, 16'h0018, 0, 16'h0000, 1, 1, 0);
    add(0, 1, 16'h0008, 0, 16'h0000, 1, 1, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    add(1, 1, 16'h1000, 1, 16'h2007, 1, 0, 0);
    add(0, 1, 16'h1000, 1, 16'h2007, 1, 1, 0);
    add(0, 1, 16'h1000, 1, 16'h2007, 1, 0, 1);
    add(0, 1, 16'h1000, 1, 16'h2007, 1, 1, 0);
    add(0, 1, 16'h1000, 1, 16'h2007, 1, 0, 1);
    add(0, 1, 16'h1000, 1, 16'h2007, 0, 0, 0);
    add(0, 1, 16'h1000, 1, 16'h2007, 0, 0, 0);
    add(0, 1, 16'h1000, 1, 16'h2007, 0, 0, 0);
    add(0, 1, 16'h1000, 1, 16'h2007, 1, 1, 0);
    add(0, 1, 16'h1000, 1, 16'h2007, 1, 0, 1);
    add(0, 0, 16'h0000, 1, 16'hFFF8, 1, 0, 1);
    add(0, 0, 16'h0000, 1, 16'hFFF7, 1, 0, 1);
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    add(0, 1, 16'h0123, 0, 16'h0000, 0, 1, 0);
    add(1, 1, 16'h1000, 1, 16'h2007, 0, 0, 0);
    add(0, 1, 16'h1000, 1, 16'h2007, 0, 1, 0);
    add(0, 1, 16'h1000, 1, 16'h2007, 1, 0, 1);
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      exp_t e;
      v = vecs[i];
      @(posedge clk); #1;
      applyStimulus(v);
      #1;
      checkOutput($sformatf("row%0d din0_ready", i), din0_ready, v.er0);
      checkOutput($sformatf("row%0d din1_ready", i), din1_ready, v.er1);
      checkOutput($sformatf("row%0d dout_valid", i), dout_valid, model_valid);
      if (model_valid) begin
        if (sb.size() == 0) begin
          checkOutput($sformatf("row%0d scoreboard underflow", i), 1, 0);
        end else begin
          checkOutput($sformatf("row%0d dout_data", i), dout_data, sb[0].data);
          checkOutput($sformatf("row%0d dout_src", i), dout_src, sb[0].src);
          if (v.dr) void'(sb.pop_front());
        end
      end
      if (v.rst) begin
        sb.delete();
        model_valid = 1'b0;
      end else if (v.er0 || v.er1) begin
        e.data = round_ref(v.er1 ? v.d1 : v.d0);
        e.src  = v.er1;
        sb.push_back(e);
        model_valid = 1'b1;
      end else if (v.dr) begin
        model_valid = 1'b0;
      end
    end

    checkOutput("scoreboard empty at end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/round_rr_arbiter.md
Name: round_rr_arbiter

Overview:
- Shares one round-half-up rounding stage between two requester streams using round-robin arbitration.
- Sits in front of fixed-point consumers where two producers need rounded results but one rounder and one output channel must be used.
- The output is registered (one pipeline stage) and tagged with the source index so downstream logic can demultiplex.
- All interfaces are valid/ready handshakes.

Parameters:
- DIN, 16, data width of both inputs and the output; must be >= 2.
- NBITS, 4, number of LSBs rounded away; legal range 1..DIN-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din0_ready  output  1  requester 0 may transfer this cycle.
- din0_valid  input  1  requester 0 data valid.
- din0_data  input  DIN  requester 0 operand.
- din1_ready  output  1  requester 1 may transfer this cycle.
- din1_valid  input  1  requester 1 data valid.
- din1_data  input  DIN  requester 1 operand.
- dout_ready  input  1  consumer accepts the output.
- dout_valid  output  1  output register holds a result.
- dout_data  output  DIN  rounded result.
- dout_src  output  1  index (0/1) of the requester that produced dout_data.

Behaviour:
- **Reset values:**
  - dout_valid=0, dout_data=0, dout_src=0.
  - Priority pointer prio=0 (requester 0 preferred).
  - din0_ready and din1_ready are 0 while rst=1.
- **Load enable:** load_en = ~dout_valid | dout_ready. The output register accepts new data when empty or being drained in the same cycle.
- **Grant (combinational):**
  - Only din0_valid: grant=0.
  - Only din1_valid: grant=1.
  - Both valid: grant=prio.
  - Neither valid: no grant.
- **Ready rules:**
  - dinX_ready = load_en & dinX_valid & (grant==X) & ~rst.
  - At most one ready is high per cycle.
  - Ready may depend on valid; valid must never depend on ready.
- **Transfer:** a transfer on input X occurs when dinX_valid & dinX_ready. On the next edge:
  - dout_valid<=1.
  - dout_data<=round(dinX_data).
  - dout_src<=X.
  - prio<=~X.
- **Drain without reload:** if dout_valid & dout_ready and no transfer occurs, dout_valid<=0. dout_data and dout_src hold their last values.
- **Backpressure:** if dout_valid & ~dout_ready, the output register holds. Both input readys are 0 and prio is unchanged.
- **Throughput and latency:**
  - One result per cycle under continuous dout_ready.
  - Latency is exactly 1 cycle from input transfer to dout_valid.
- **Rounding arithmetic:**
  - sum = dinX_data + 2^(NBITS-1), computed modulo 2^DIN (carry out discarded).
  - result = sum with bits [NBITS-1:0] forced to 0.
  - Operands are treated as raw unsigned vectors. Signed two's-complement inputs therefore round toward +inf at exact halves.
- **Wrap-around:** values at or above 2^DIN - 2^(NBITS-1) wrap to 0; no saturation.
- **Fairness:**
  - prio changes only on an actual transfer.
  - With both inputs continuously valid and dout_ready=1, grants alternate 0,1,0,1 starting from 0 after reset.
  - A lone requester is served every cycle regardless of prio.
- **Simultaneous events:** a drain and a load in the same cycle keep dout_valid=1 with no bubble.
- **Reset mid-operation:**
  - Any held output is discarded and prio returns to 0.
  - No input transfer occurs in a cycle with rst=1.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then inputs low -> dout_valid=0, dout_data=0, dout_src=0, both readys 0.
- Single source, DIN=16, NBITS=4: din0 presents 0x0017, 0x0018, 0x0008, with dout_ready=1 -> dout 0x0010, 0x0020, 0x0010 on consecutive cycles, dout_src=0, 1-cycle latency.
- Contention: both valid every cycle, din0=0x1000, din1=0x2007, dout_ready=1 -> outputs alternate (src0, 0x1000), (src1, 0x2000), ...; first grant goes to din0.
- Backpressure: output held with dout_ready=0 for 3 cycles while both inputs valid -> dout stable, both readys 0, prio unchanged. When dout_ready returns, the pending grant goes to the prio source and there is no bubble.
- Wrap: din1=0xFFF8, NBITS=4 -> dout_data=0x0000, dout_src=1. Also din1=0xFFF7 -> 0xFFF0.
- Mid-stream reset: assert rst with dout_valid=1 and prio=1 -> next cycle dout_valid=0 and prio=0. With both inputs valid after reset, din0 is granted first.
